// File: rtl/spi_flash_pkg.sv
// Shared command codes, FSM state type and helpers for the SPI flash read responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_RDID  = 8'h9F;
  localparam int         ADDR_BITS = 24;
  localparam logic [4:0] CMD_LAST  = 5'd7;
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_READ   = 3'd3,
    S_RDID   = 3'd4,
    S_IGNORE = 3'd5
  } state_e;

  // Selects the next READ-ID byte; every index past the last ID byte yields the fill byte.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx,
                                         input logic [7:0] fill);
    logic [7:0] b;
    case (idx)
      2'd0:    b = id[23:16];
      2'd1:    b = id[15:8];
      2'd2:    b = id[7:0];
      default: b = fill;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Oversamples the SPI pins: two-flop synchronizer plus a third flop used as the
// edge reference; edge strobes and MOSI leave this block registered and aligned.
module spi_pin_sync (
  input  logic clk,
  input  logic reset,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [2:0] sck_sync_r;
  logic [2:0] cs_sync_r;
  logic [1:0] mosi_sync_r;
  logic       sck_rise_r, sck_fall_r, cs_fall_r, cs_rise_r, mosi_r;

  // Synchronizer chains; CS idles high so it resets to the inactive level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_r  <= 3'b000;
      cs_sync_r   <= 3'b111;
      mosi_sync_r <= 2'b00;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], spi_clk};
      cs_sync_r   <= {cs_sync_r[1:0], spi_cs};
      mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
    end
  end

  // Edge strobes compare the synchronized sample against the third flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_rise_r <= 1'b0;
      sck_fall_r <= 1'b0;
      cs_fall_r  <= 1'b0;
      cs_rise_r  <= 1'b0;
      mosi_r     <= 1'b0;
    end else begin
      sck_rise_r <= sck_sync_r[1] & ~sck_sync_r[2];
      sck_fall_r <= ~sck_sync_r[1] & sck_sync_r[2];
      cs_fall_r  <= ~cs_sync_r[1] & cs_sync_r[2];
      cs_rise_r  <= cs_sync_r[1] & ~cs_sync_r[2];
      mosi_r     <= mosi_sync_r[1];
    end
  end

  assign sck_rise = sck_rise_r;
  assign sck_fall = sck_fall_r;
  assign cs_fall  = cs_fall_r;
  assign cs_rise  = cs_rise_r;
  assign mosi_s   = mosi_r;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI Mode 0 slave emulating a serial-flash READ port: decodes READ / READ-ID and
// streams bytes from a req/ack memory port with one-byte prefetch and auto-increment.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_SPI_CLK,
  input  logic              i_SPI_CS,
  input  logic              i_SPI_MOSI,
  output logic              o_SPI_MISO,
  output logic              o_SPI_MISO_OE,
  output logic [ADDR_W-1:0] o_MEM_ADDRESS,
  output logic              o_MEM_REQ,
  input  logic [7:0]        i_MEM_DATA,
  input  logic              i_MEM_ACK,
  output logic              o_BUSY,
  output logic              o_UNDERRUN
);

  logic              sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s, mosi_s;
  state_e            state_r, state_nxt_s;
  logic [4:0]        bit_cnt_r;
  logic [2:0]        fall_cnt_r;
  logic [1:0]        id_idx_r;
  logic [ADDR_W-2:0] shift_in_r;
  logic [ADDR_W-1:0] rx_word_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        shift_out_r, hold_r, load_byte_s;
  logic              hold_vld_r, mem_req_r, miso_r, oe_r, busy_r, underrun_r;
  logic              shift_in_en_s, cmd_done_s, addr_done_s, load_mem_s, load_id_s, shift_out_s;

  spi_pin_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .spi_clk  (i_SPI_CLK),
    .spi_cs   (i_SPI_CS),
    .spi_mosi (i_SPI_MOSI),
    .sck_rise (sck_rise_s),
    .sck_fall (sck_fall_s),
    .cs_fall  (cs_fall_s),
    .cs_rise  (cs_rise_s),
    .mosi_s   (mosi_s)
  );

  // Only the low ADDR_W bits are kept: higher address bits simply fall off the shifter
  assign rx_word_s = {shift_in_r, mosi_s};

  // State register; BUSY tracks whether the next state is inside a transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
    end
  end

  // Next-state decode; CS rising aborts from any state
  always_comb begin
    state_nxt_s = state_r;
    if (cs_rise_s) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cs_fall_s) state_nxt_s = S_CMD;
          else           state_nxt_s = S_IDLE;
        end
        S_CMD: begin
          if (sck_rise_s && bit_cnt_r == CMD_LAST) begin
            if (rx_word_s[7:0] == CMD_READ)      state_nxt_s = S_ADDR;
            else if (rx_word_s[7:0] == CMD_RDID) state_nxt_s = S_RDID;
            else                                 state_nxt_s = S_IGNORE;
          end else begin
            state_nxt_s = S_CMD;
          end
        end
        S_ADDR: begin
          if (sck_rise_s && bit_cnt_r == ADDR_LAST) state_nxt_s = S_READ;
          else                                      state_nxt_s = S_ADDR;
        end
        S_READ, S_RDID, S_IGNORE: state_nxt_s = state_r;
        default:                  state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Per-state datapath strobes; a byte is loaded on the first fall of every 8
  always_comb begin
    shift_in_en_s = 1'b0;
    cmd_done_s    = 1'b0;
    addr_done_s   = 1'b0;
    load_mem_s    = 1'b0;
    load_id_s     = 1'b0;
    shift_out_s   = 1'b0;
    load_byte_s   = FILL_BYTE;
    case (state_r)
      S_CMD: begin
        shift_in_en_s = sck_rise_s;
        cmd_done_s    = sck_rise_s & (bit_cnt_r == CMD_LAST);
      end
      S_ADDR: begin
        shift_in_en_s = sck_rise_s;
        addr_done_s   = sck_rise_s & (bit_cnt_r == ADDR_LAST);
      end
      S_READ: begin
        load_mem_s  = sck_fall_s & (fall_cnt_r == 3'd0);
        shift_out_s = sck_fall_s & (fall_cnt_r != 3'd0);
      end
      S_RDID: begin
        load_id_s   = sck_fall_s & (fall_cnt_r == 3'd0);
        shift_out_s = sck_fall_s & (fall_cnt_r != 3'd0);
      end
      default: shift_in_en_s = 1'b0;
    endcase
    if (load_mem_s) begin
      load_byte_s = hold_vld_r ? hold_r : FILL_BYTE;
    end else begin
      load_byte_s = id_byte(JEDEC_ID, id_idx_r, FILL_BYTE);
    end
  end

  // Shifters, prefetching memory port and MISO drive; CS rise discards everything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_r   <= 5'd0;
      fall_cnt_r  <= 3'd0;
      id_idx_r    <= 2'd0;
      shift_in_r  <= '0;
      shift_out_r <= 8'h00;
      hold_r      <= 8'h00;
      hold_vld_r  <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= '0;
      miso_r      <= 1'b1;
      oe_r        <= 1'b0;
      underrun_r  <= 1'b0;
    end else if (cs_rise_s) begin
      bit_cnt_r   <= 5'd0;
      fall_cnt_r  <= 3'd0;
      id_idx_r    <= 2'd0;
      shift_in_r  <= '0;
      shift_out_r <= 8'h00;
      hold_vld_r  <= 1'b0;
      mem_req_r   <= 1'b0;
      miso_r      <= 1'b1;
      oe_r        <= 1'b0;
    end else begin
      if (cs_fall_s && state_r == S_IDLE) begin
        bit_cnt_r  <= 5'd0;
        fall_cnt_r <= 3'd0;
        id_idx_r   <= 2'd0;
        hold_vld_r <= 1'b0;
      end
      if (shift_in_en_s) begin
        shift_in_r <= rx_word_s[ADDR_W-2:0];
        bit_cnt_r  <= (cmd_done_s || addr_done_s) ? 5'd0 : bit_cnt_r + 5'd1;
      end
      if (addr_done_s) begin
        mem_addr_r <= rx_word_s;
        mem_req_r  <= 1'b1;
        hold_vld_r <= 1'b0;
      end
      if (load_mem_s || load_id_s) begin
        shift_out_r <= load_byte_s;
        miso_r      <= load_byte_s[7];
        oe_r        <= 1'b1;
        fall_cnt_r  <= fall_cnt_r + 3'd1;
      end
      if (shift_out_s) begin
        shift_out_r <= {shift_out_r[6:0], 1'b0};
        miso_r      <= shift_out_r[6];
        fall_cnt_r  <= fall_cnt_r + 3'd1;
      end
      if (load_id_s && id_idx_r != 2'd3) begin
        id_idx_r <= id_idx_r + 2'd1;
      end
      if (load_mem_s) begin
        mem_addr_r <= mem_addr_r + ADDR_W'(1);
        mem_req_r  <= 1'b1;
        hold_vld_r <= 1'b0;
        if (!hold_vld_r) underrun_r <= 1'b1;
      end
      // A late ack landing on a load still fills the holding reg; the new request stays up
      if (i_MEM_ACK && mem_req_r) begin
        hold_r     <= i_MEM_DATA;
        hold_vld_r <= 1'b1;
        if (!load_mem_s) mem_req_r <= 1'b0;
      end
    end
  end

  assign o_SPI_MISO    = miso_r;
  assign o_SPI_MISO_OE = oe_r;
  assign o_MEM_ADDRESS = mem_addr_r;
  assign o_MEM_REQ     = mem_req_r;
  assign o_BUSY        = busy_r;
  assign o_UNDERRUN    = underrun_r;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: directed vector table, randomized
// transactions against a byte-level reference model, and abort/reset/underrun sequences.
module tb_spi_flash_responder;

  localparam int ADDR_W = 12;
  localparam int HALF   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_SPI_CLK, i_SPI_CS, i_SPI_MOSI;
  logic              o_SPI_MISO, o_SPI_MISO_OE;
  logic [ADDR_W-1:0] o_MEM_ADDRESS;
  logic              o_MEM_REQ;
  logic [7:0]        i_MEM_DATA;
  logic              i_MEM_ACK;
  logic              o_BUSY, o_UNDERRUN;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]        mem [0:4095];
  int                mem_lat = 2;
  int                req_cnt = 0;
  int                ack_cnt = 0;
  logic [ADDR_W-1:0] ack_addr_log [0:255];

  logic [7:0] rx_bytes [0:15];
  logic       data_oe_all, data_oe_any, busy_mid;
  int         req_base, ack_base;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [3:0]  nbytes;
    logic [3:0]  lat;
    logic [47:0] exp;
    logic        exp_oe;
    logic        exp_req;
  } vec_t;

  vec_t vecs [0:4];

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk           (clk),
    .reset         (reset),
    .i_SPI_CLK     (i_SPI_CLK),
    .i_SPI_CS      (i_SPI_CS),
    .i_SPI_MOSI    (i_SPI_MOSI),
    .o_SPI_MISO    (o_SPI_MISO),
    .o_SPI_MISO_OE (o_SPI_MISO_OE),
    .o_MEM_ADDRESS (o_MEM_ADDRESS),
    .o_MEM_REQ     (o_MEM_REQ),
    .i_MEM_DATA    (i_MEM_DATA),
    .i_MEM_ACK     (i_MEM_ACK),
    .o_BUSY        (o_BUSY),
    .o_UNDERRUN    (o_UNDERRUN)
  );

  // Memory: acks a held request after mem_lat cycles with the byte at the current address
  initial begin : mem_model
    int cnt;
    cnt        = 0;
    i_MEM_ACK  = 1'b0;
    i_MEM_DATA = 8'h00;
    forever begin
      @(negedge clk);
      i_MEM_ACK = 1'b0;
      if (o_MEM_REQ === 1'b1) begin
        req_cnt++;
        cnt++;
        if (cnt >= mem_lat) begin
          i_MEM_ACK  = 1'b1;
          i_MEM_DATA = mem[o_MEM_ADDRESS];
          ack_addr_log[ack_cnt % 256] = o_MEM_ADDRESS;
          ack_cnt++;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    rx     = 8'h00;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int b = 7; b > 7 - nbits; b--) begin
      i_SPI_MOSI = tx[b];
      repeat (HALF) @(negedge clk);
      rx[b]  = o_SPI_MISO;
      oe_all = oe_all & o_SPI_MISO_OE;
      oe_any = oe_any | o_SPI_MISO_OE;
      i_SPI_CLK = 1'b1;
      repeat (HALF) @(negedge clk);
      i_SPI_CLK = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
    logic [7:0] rx;
    logic       a, y;
    req_base    = req_cnt;
    ack_base    = ack_cnt;
    data_oe_all = 1'b1;
    data_oe_any = 1'b0;
    i_SPI_CS = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(cmd, 8, rx, a, y);
    busy_mid = o_BUSY;
    if (cmd == 8'h03) begin
      for (int i = 2; i >= 0; i--) spi_bits(addr[8*i +: 8], 8, rx, a, y);
    end
    for (int i = 0; i < nbytes; i++) begin
      spi_bits(8'h00, 8, rx, a, y);
      rx_bytes[i] = rx;
      data_oe_all = data_oe_all & a;
      data_oe_any = data_oe_any | y;
    end
    repeat (HALF) @(negedge clk);
    i_SPI_CS = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Reference model: byte i of a transaction, from the flash command semantics
  function automatic logic [7:0] model_byte(input logic [7:0] cmd, input logic [23:0] addr,
                                            input int i);
    logic [23:0] jedec;
    jedec = 24'hEF4016;
    if (cmd == 8'h03) return mem[(int'(addr[11:0]) + i) % 4096];
    if (i < 3)        return jedec[23 - 8*i -: 8];
    return 8'hFF;
  endfunction

  initial begin : main
    logic [7:0]  cmd, rx, exp_b;
    logic [23:0] addr;
    logic        a, y;
    int          nb, r;

    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    vecs[0] = '{8'h03, 24'h000123, 4'd4, 4'd2, 48'h2324_2526_0000, 1'b1, 1'b1};
    vecs[1] = '{8'h03, 24'h000FFE, 4'd3, 4'd2, 48'hFEFF_0000_0000, 1'b1, 1'b1};
    vecs[2] = '{8'h9F, 24'h000000, 4'd5, 4'd2, 48'hEF40_16FF_FF00, 1'b1, 1'b0};
    vecs[3] = '{8'h02, 24'h000000, 4'd2, 4'd2, 48'h0000_0000_0000, 1'b0, 1'b0};
    vecs[4] = '{8'h03, 24'h000010, 4'd2, 4'd3, 48'h1011_0000_0000, 1'b1, 1'b1};

    i_SPI_CLK  = 1'b0;
    i_SPI_CS   = 1'b1;
    i_SPI_MOSI = 1'b0;
    reset      = 1'b0;
    #1 reset   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset miso", 32'(o_SPI_MISO), 32'd1);
    check("reset oe", 32'(o_SPI_MISO_OE), 32'd0);
    check("reset req", 32'(o_MEM_REQ), 32'd0);
    check("reset addr", 32'(o_MEM_ADDRESS), 32'd0);
    check("reset busy", 32'(o_BUSY), 32'd0);
    check("reset underrun", 32'(o_UNDERRUN), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      nb      = int'(vecs[v].nbytes);
      mem_lat = int'(vecs[v].lat);
      run_txn(vecs[v].cmd, vecs[v].addr, nb);
      check($sformatf("vec%0d busy", v), 32'(busy_mid), 32'd1);
      if (vecs[v].exp_oe) begin
        check($sformatf("vec%0d oe", v), 32'(data_oe_all), 32'd1);
        for (int i = 0; i < nb; i++)
          check($sformatf("vec%0d byte%0d", v, i), 32'(rx_bytes[i]), 32'(vecs[v].exp[47 - 8*i -: 8]));
      end else begin
        check($sformatf("vec%0d oe off", v), 32'(data_oe_any), 32'd0);
      end
      check($sformatf("vec%0d req", v), 32'(req_cnt != req_base), 32'(vecs[v].exp_req));
      if (vecs[v].exp_req) begin
        for (int i = 0; i < nb; i++)
          check($sformatf("vec%0d ack addr%0d", v, i), 32'(ack_addr_log[(ack_base + i) % 256]),
                32'((int'(vecs[v].addr[11:0]) + i) % 4096));
      end
      check($sformatf("vec%0d busy end", v), 32'(o_BUSY), 32'd0);
      check($sformatf("vec%0d underrun", v), 32'(o_UNDERRUN), 32'd0);
    end

    // Randomized transactions against the model
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 20; t++) begin
      r = int'($urandom_range(0, 3));
      if (r < 2)       cmd = 8'h03;
      else if (r == 2) cmd = 8'h9F;
      else begin
        cmd = 8'($urandom);
        while (cmd == 8'h03 || cmd == 8'h9F) cmd = 8'($urandom);
      end
      addr    = 24'($urandom);
      nb      = int'($urandom_range(1, 6));
      mem_lat = int'($urandom_range(1, 4));
      run_txn(cmd, addr, nb);
      if (cmd == 8'h03 || cmd == 8'h9F) begin
        check($sformatf("rnd%0d oe", t), 32'(data_oe_all), 32'd1);
        for (int i = 0; i < nb; i++) begin
          exp_b = model_byte(cmd, addr, i);
          check($sformatf("rnd%0d cmd%0h byte%0d", t, cmd, i), 32'(rx_bytes[i]), 32'(exp_b));
        end
      end else begin
        check($sformatf("rnd%0d oe off", t), 32'(data_oe_any), 32'd0);
      end
      check($sformatf("rnd%0d req", t), 32'(req_cnt != req_base), 32'(cmd == 8'h03));
    end
    check("rnd underrun", 32'(o_UNDERRUN), 32'd0);

    // CS raised after 10 address bits, then stray SCK with CS high
    mem_lat  = 2;
    i_SPI_CS = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h03, 8, rx, a, y);
    spi_bits(8'h00, 8, rx, a, y);
    spi_bits(8'h12, 2, rx, a, y);
    i_SPI_CS = 1'b1;
    repeat (4) @(negedge clk);
    check("abort busy", 32'(o_BUSY), 32'd0);
    check("abort oe", 32'(o_SPI_MISO_OE), 32'd0);
    check("abort req", 32'(o_MEM_REQ), 32'd0);
    req_base = req_cnt;
    for (int k = 0; k < 4; k++) begin
      i_SPI_CLK = 1'b1;
      repeat (HALF) @(negedge clk);
      i_SPI_CLK = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    check("idle sck busy", 32'(o_BUSY), 32'd0);
    check("idle sck req", 32'(req_cnt != req_base), 32'd0);
    run_txn(8'h03, 24'hABC300, 2);
    for (int i = 0; i < 2; i++)
      check($sformatf("post abort byte%0d", i), 32'(rx_bytes[i]), 32'(mem[12'h300 + 12'(i)]));

    // Ack far later than the first data fall
    mem_lat = 40;
    run_txn(8'h03, 24'h000050, 2);
    check("underrun first byte", 32'(rx_bytes[0]), 32'hFF);
    check("underrun oe", 32'(data_oe_all), 32'd1);
    check("underrun sticky", 32'(o_UNDERRUN), 32'd1);
    check("underrun idle oe", 32'(o_SPI_MISO_OE), 32'd0);

    // Reset pulsed mid-READ
    mem_lat  = 2;
    i_SPI_CS = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h03, 8, rx, a, y);
    spi_bits(8'h00, 8, rx, a, y);
    spi_bits(8'h02, 8, rx, a, y);
    spi_bits(8'h00, 8, rx, a, y);
    spi_bits(8'h00, 8, rx, a, y);
    check("pre-reset oe", 32'(o_SPI_MISO_OE), 32'd1);
    reset = 1'b1;
    #1;
    check("midreset miso", 32'(o_SPI_MISO), 32'd1);
    check("midreset oe", 32'(o_SPI_MISO_OE), 32'd0);
    check("midreset req", 32'(o_MEM_REQ), 32'd0);
    check("midreset addr", 32'(o_MEM_ADDRESS), 32'd0);
    check("midreset busy", 32'(o_BUSY), 32'd0);
    check("midreset underrun", 32'(o_UNDERRUN), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    i_SPI_CS = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("post reset busy", 32'(o_BUSY), 32'd0);
    check("post reset oe", 32'(o_SPI_MISO_OE), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
SPI Mode 0 slave that emulates a serial flash READ port, so an external SPI master (or the board's own flash master in loopback test) can read the on-chip byte memory. It decodes READ (0x03) and READ-ID (0x9F), captures a 24-bit address, and streams bytes from a req/ack memory port with auto-increment until chip select deasserts. All SPI pins are oversampled in the system clock domain.

Parameters:
ADDR_W, 12, width of memory address; SPI address bits above ADDR_W-1 are ignored
JEDEC_ID, 24'hEF4016, 3 bytes returned MSB-first by READ-ID
FILL_BYTE, 8'hFF, byte shifted out on memory underrun or after ID bytes exhausted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_SPI_CLK  in  1  SPI clock from master (Mode 0, idle low)
i_SPI_CS  in  1  SPI chip select, active low
i_SPI_MOSI  in  1  master-out data
o_SPI_MISO  out  1  slave-out data
o_SPI_MISO_OE  out  1  MISO drive enable (pad tristates when 0)
o_MEM_ADDRESS  out  ADDR_W  memory byte address
o_MEM_REQ  out  1  read request, held until ack
i_MEM_DATA  in  8  read data, valid with ack
i_MEM_ACK  in  1  one-cycle completion of request
o_BUSY  out  1  synchronized CS active
o_UNDERRUN  out  1  sticky: a byte was due before memory ack

Behaviour:
- Reset (async, high): state IDLE; o_SPI_MISO=1, o_SPI_MISO_OE=0, o_MEM_REQ=0, o_MEM_ADDRESS=0, o_BUSY=0, o_UNDERRUN=0; counters, shift/holding regs cleared.
- Inputs pass a 2-flop synchronizer; rise/fall of SCK and CS detected on the 3rd flop. Requirement: SCK high and low phases each >=4 clk; CS assert to first SCK rise >=4 clk.
- Sample MOSI on SCK rising edge; update MISO on SCK falling edge (and on data-phase entry, see below). MSB first.
- States: IDLE, CMD, ADDR, READ, RDID, IGNORE.
- IDLE -> CMD on CS falling edge; bit counter=0; o_BUSY=1.
- CMD: after 8th rise, 0x03 -> ADDR, 0x9F -> RDID, else -> IGNORE.
- ADDR: shift 24 bits; on 24th rise latch o_MEM_ADDRESS = addr[ADDR_W-1:0], assert o_MEM_REQ, -> READ.
- READ: on first SCK fall after entry and every 8th fall thereafter, load shifter from holding reg, drive bit7, set OE=1; if holding reg empty load FILL_BYTE and set o_UNDERRUN. On each load, o_MEM_ADDRESS increments (wraps 2^ADDR_W-1 -> 0) and new REQ issued (prefetch one byte ahead). Other falls shift left.
- Memory: REQ held until ack cycle; on ack capture i_MEM_DATA into holding reg (valid=1), REQ drops the same edge. Ack with REQ=0 ignored. Master must leave >=half SCK period between last address bit and first data fall for first byte.
- RDID: on 8th-rise-following fall load JEDEC_ID[23:16], then [15:8], [7:0], then FILL_BYTE repeatedly; OE=1.
- IGNORE: OE=0, no memory requests, until CS rises.
- CS rising edge in any state (including mid-byte, mid-address): -> IDLE next clk, OE=0, REQ dropped, holding reg invalidated, partial bits discarded, o_BUSY=0. An outstanding ack arriving after is ignored.
- o_UNDERRUN clears only on reset.
- SCK edges while CS high ignored.

Decomposition:
- Package spi_flash_pkg: CMD_READ=8'h03, CMD_RDID=8'h9F, state enum, ADDR_BITS=24.
- Sub-module spi_pin_sync: 2-flop synchronizer + edge detector for SCK/CS/MOSI, outputs sck_rise, sck_fall, cs_fall, cs_rise, mosi_s.

Test Plan:
- READ 0x03 + addr 0x000123, memory returns addr[7:0] with 2-clk ack latency, 4 bytes clocked -> MISO bytes 0x23,0x24,0x25,0x26; o_UNDERRUN=0.
- ADDR_W=12, READ at 0x000FFE, 3 bytes -> o_MEM_ADDRESS sequence 0xFFE,0xFFF,0x000; data wraps accordingly.
- 0x9F, 5 bytes clocked -> 0xEF,0x40,0x16,0xFF,0xFF.
- Command 0x02 then 16 SCKs -> OE stays 0, o_MEM_REQ never asserts; next CS cycle with 0x03 works normally.
- Ack delayed beyond first data fall -> first byte 0xFF, o_UNDERRUN=1 and stays 1 after CS rise.
- CS deasserted after 10 address bits; reset pulsed mid-READ -> IDLE, OE=0, REQ=0, all outputs at reset values within 1 clk (reset) / 4 clk (CS).
